// File: rtl/rx_low_pass_fir_ctrl_pkg.sv
// Shared constants and FSM encoding for the receive low-pass FIR sequencer.
package rx_lpf_pkg;

    localparam int N_TAPS    = 128;
    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 16;
    localparam int ACC_W     = 40;
    localparam int OUT_SHIFT = 15;

    localparam logic signed [DATA_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [DATA_W-1:0] SAT_MIN = 16'sh8000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } state_e;

endpackage

// File: rtl/rx_low_pass_fir_ctrl_if.sv
// Sample input, status, BRAM port and filtered-output bundle of the FIR sequencer.
interface rx_low_pass_fir_ctrl_if;
    import rx_lpf_pkg::*;

    // sample_valid is a one-cycle strobe with no ready: it is taken only when the
    // sequencer is idle, otherwise the sample is dropped and overrun latches.
    // fir_valid is a one-cycle strobe qualifying fir_out.
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic              busy;
    logic              overrun;
    logic              smp_ena;
    logic              smp_wea;
    logic [ADDR_W-1:0] smp_addra;
    logic [DATA_W-1:0] smp_dia;
    logic              smp_enb;
    logic [ADDR_W-1:0] smp_addrb;
    logic [DATA_W-1:0] smp_dob;
    logic              coef_enb;
    logic [ADDR_W-1:0] coef_addrb;
    logic [DATA_W-1:0] coef_dob;
    logic [DATA_W-1:0] fir_out;
    logic              fir_valid;
    state_e            state_dbg;

    modport master (
        input  sample_in, sample_valid, smp_dob, coef_dob,
        output busy, overrun, smp_ena, smp_wea, smp_addra, smp_dia,
               smp_enb, smp_addrb, coef_enb, coef_addrb,
               fir_out, fir_valid, state_dbg
    );

    modport slave (
        output sample_in, sample_valid, smp_dob, coef_dob,
        input  busy, overrun, smp_ena, smp_wea, smp_addra, smp_dia,
               smp_enb, smp_addrb, coef_enb, coef_addrb,
               fir_out, fir_valid, state_dbg
    );

endinterface

// File: rtl/rx_low_pass_fir_ctrl_mac.sv
// Product register, accumulator and output scaling/saturation of the FIR.
// Build option RX_LPF_ROUND_EN selects round-half-up instead of floor before saturation.
module rx_lpf_mac
    import rx_lpf_pkg::*;
(
    input  logic                     clk,
    input  logic                     rrx_rst,
    input  logic signed [DATA_W-1:0] smp_i,
    input  logic signed [DATA_W-1:0] coef_i,
    input  logic                     prod_en_i,
    input  logic                     acc_clr_i,
    input  logic                     acc_en_i,
    input  logic                     load_i,
    output logic        [DATA_W-1:0] fir_out_o
);

    localparam logic signed [ACC_W-1:0] HI_EXT = {{(ACC_W-DATA_W){1'b0}}, SAT_MAX};
    localparam logic signed [ACC_W-1:0] LO_EXT = {{(ACC_W-DATA_W){1'b1}}, SAT_MIN};

    logic signed [2*DATA_W-1:0] prod_q;
    logic signed [ACC_W-1:0]    acc_q;
    logic        [DATA_W-1:0]   fir_q;
    logic signed [ACC_W-1:0]    acc_adj;
    logic signed [ACC_W-1:0]    shifted;
    logic        [DATA_W-1:0]   sat_res;

`ifdef RX_LPF_ROUND_EN
    localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (OUT_SHIFT - 1);
    assign acc_adj = acc_q + RND;
`else
    assign acc_adj = acc_q;
`endif

    always_comb begin
        shifted = acc_adj >>> OUT_SHIFT;
        sat_res = shifted[DATA_W-1:0];
        if (shifted > HI_EXT) begin
            sat_res = SAT_MAX;
        end else if (shifted < LO_EXT) begin
            sat_res = SAT_MIN;
        end
    end

    always_ff @(posedge clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            prod_q <= '0;
            acc_q  <= '0;
            fir_q  <= '0;
        end else begin
            if (prod_en_i) begin
                prod_q <= smp_i * coef_i;
            end
            if (acc_clr_i) begin
                acc_q <= '0;
            end else if (acc_en_i) begin
                acc_q <= acc_q + {{(ACC_W-2*DATA_W){prod_q[2*DATA_W-1]}}, prod_q};
            end
            if (load_i) begin
                fir_q <= sat_res;
            end
        end
    end

    assign fir_out_o = fir_q;

endmodule

// File: rtl/rx_low_pass_fir_ctrl.sv
// FIR sequencer: writes each accepted sample into the circular buffer, walks all
// taps through the sample/coefficient BRAMs and emits one saturated result.
module rx_low_pass_fir_ctrl
    import rx_lpf_pkg::*;
(
    input  logic                   clk,
    input  logic                   rrx_rst,
    rx_low_pass_fir_ctrl_if.master bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic [1:0]        drain_q, drain_d;
    logic              overrun_q, overrun_d;
    logic              prod_en_q, acc_en_q;
    logic              acc_clr, load_out;
    logic              smp_ena, smp_wea, smp_enb, coef_enb;
    logic [ADDR_W-1:0] smp_addra, smp_addrb, coef_addrb;
    logic [DATA_W-1:0] smp_dia;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        base_d     = base_q;
        k_d        = k_q;
        sample_d   = sample_q;
        drain_d    = drain_q;
        overrun_d  = overrun_q;
        acc_clr    = 1'b0;
        load_out   = 1'b0;
        smp_ena    = 1'b0;
        smp_wea    = 1'b0;
        smp_addra  = '0;
        smp_dia    = '0;
        smp_enb    = 1'b0;
        smp_addrb  = '0;
        coef_enb   = 1'b0;
        coef_addrb = '0;

        if (bus.sample_valid && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.sample_valid) begin
                    sample_d = bus.sample_in;
                    base_d   = wr_ptr_q;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                smp_ena   = 1'b1;
                smp_wea   = 1'b1;
                smp_addra = base_q;
                smp_dia   = sample_q;
                wr_ptr_d  = wr_ptr_q + 1'b1;
                k_d       = '0;
                acc_clr   = 1'b1;
                state_d   = MAC;
            end
            MAC: begin
                // Newest sample is tap 0, so the sample address walks backwards.
                smp_enb    = 1'b1;
                coef_enb   = 1'b1;
                smp_addrb  = base_q - k_q;
                coef_addrb = k_q;
                k_d        = k_q + 1'b1;
                if (k_q == ADDR_W'(N_TAPS - 1)) begin
                    drain_d = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == 2'd2) begin
                    load_out = 1'b1;
                    state_d  = OUT;
                end
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            base_q    <= '0;
            k_q       <= '0;
            sample_q  <= '0;
            drain_q   <= '0;
            overrun_q <= 1'b0;
            prod_en_q <= 1'b0;
            acc_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            base_q    <= base_d;
            k_q       <= k_d;
            sample_q  <= sample_d;
            drain_q   <= drain_d;
            overrun_q <= overrun_d;
            // BRAM read latency: product one cycle after the address, accumulate one after that.
            prod_en_q <= (state_q == MAC);
            acc_en_q  <= prod_en_q;
        end
    end

    rx_lpf_mac u_mac (
        .clk       (clk),
        .rrx_rst   (rrx_rst),
        .smp_i     (bus.smp_dob),
        .coef_i    (bus.coef_dob),
        .prod_en_i (prod_en_q),
        .acc_clr_i (acc_clr),
        .acc_en_i  (acc_en_q),
        .load_i    (load_out),
        .fir_out_o (bus.fir_out)
    );

    assign bus.busy       = (state_q != IDLE);
    assign bus.overrun    = overrun_q;
    assign bus.fir_valid  = (state_q == OUT);
    assign bus.state_dbg  = state_q;
    assign bus.smp_ena    = smp_ena;
    assign bus.smp_wea    = smp_wea;
    assign bus.smp_addra  = smp_addra;
    assign bus.smp_dia    = smp_dia;
    assign bus.smp_enb    = smp_enb;
    assign bus.smp_addrb  = smp_addrb;
    assign bus.coef_enb   = coef_enb;
    assign bus.coef_addrb = coef_addrb;

endmodule

// File: tb/tb_rx_low_pass_fir_ctrl.sv
// Bench for rx_low_pass_fir_ctrl: BRAM models, tap-sum reference model, scenario tasks.
module tb_rx_low_pass_fir_ctrl;
  import rx_lpf_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rrx_rst = 1'b1;
  logic mem_clr = 1'b0;
  always #5 clk = ~clk;

  rx_low_pass_fir_ctrl_if bus();

  rx_low_pass_fir_ctrl dut (
    .clk     (clk),
    .rrx_rst (rrx_rst),
    .bus     (bus)
  );

  // ---------------- BRAM models (registered read, 1-cycle latency) ----------------
  logic [15:0] smp_mem [128];
  logic [15:0] coef_mem [128];
  logic [15:0] smp_dob_r = 16'h0;
  logic [15:0] coef_dob_r = 16'h0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 128; i++) smp_mem[i] <= 16'h0;
    end else if (bus.smp_ena && bus.smp_wea) begin
      smp_mem[bus.smp_addra] <= bus.smp_dia;
    end
    if (bus.smp_enb) smp_dob_r <= smp_mem[bus.smp_addrb];
    if (bus.coef_enb) coef_dob_r <= coef_mem[bus.coef_addrb];
  end

  assign bus.smp_dob  = smp_dob_r;
  assign bus.coef_dob = coef_dob_r;

  // ---------------- reference model + scoreboard ----------------
  int n_tests = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_buf [128];
  logic [15:0] coef_model [128];
  int model_ptr = 0;
  int obs_addrb [128];
  int obs_coefb [128];

  // Accept a sample into the model ring; push the expected filter output.
  task automatic model_accept(input logic [15:0] s, output int exp_addr);
    longint acc;
    longint c, x, q;
    exp_addr = model_ptr;
    model_buf[model_ptr] = s;
    acc = 0;
    for (int k = 0; k < 128; k++) begin
      c = longint'($signed(coef_model[k]));
      x = longint'($signed(model_buf[(exp_addr - k) & 127]));
      acc += c * x;
    end
`ifdef RX_LPF_ROUND_EN
    acc += 64'sd16384;
`endif
    q = acc >>> 15;
    if (q > 32767) exp_q.push_back(16'h7FFF);
    else if (q < -32768) exp_q.push_back(16'h8000);
    else exp_q.push_back(q[15:0]);
    model_ptr = (model_ptr + 1) % 128;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rrx_rst = 1'b1;
    bus.sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    rrx_rst = 1'b0;
    model_ptr = 0;
  endtask

  task automatic clear_mem();
    @(negedge clk);
    mem_clr = 1'b1;
    @(negedge clk);
    mem_clr = 1'b0;
    for (int i = 0; i < 128; i++) model_buf[i] = 16'h0;
  endtask

  task automatic load_coef(input int mode);
    for (int i = 0; i < 128; i++) begin
      case (mode)
        0: coef_mem[i] = (i == 0) ? 16'h7FFF : 16'h0;
        1: coef_mem[i] = 16'($urandom_range(0, 4095)) - 16'd2048;
        default: coef_mem[i] = 16'h7FFF;
      endcase
      coef_model[i] = coef_mem[i];
    end
  endtask

  // Pulses one sample, optionally a second strobe at offset extra_at, and
  // observes the DUT until fir_valid (bounded to 200 cycles).
  task automatic run_sample(input logic [15:0] s, input int extra_at,
                            output int lat, output logic [15:0] fout,
                            output int wea_cnt, output int enb_cnt,
                            output int addra, output logic [15:0] dia,
                            output logic pre_busy, output int idle_en_cnt);
    @(negedge clk);
    pre_busy = bus.busy;
    bus.sample_in = s;
    bus.sample_valid = 1'b1;
    lat = -1; fout = 16'h0; wea_cnt = 0; enb_cnt = 0; addra = -1; dia = 16'h0; idle_en_cnt = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      bus.sample_valid = (n == extra_at);
      if (n == extra_at) bus.sample_in = 16'($urandom);
      if (!bus.busy && (bus.smp_ena || bus.smp_wea || bus.smp_enb || bus.coef_enb)) idle_en_cnt++;
      if (bus.smp_wea) begin
        wea_cnt++;
        addra = int'(bus.smp_addra);
        dia = bus.smp_dia;
      end
      if (bus.smp_enb) begin
        if (enb_cnt < 128) begin
          obs_addrb[enb_cnt] = int'(bus.smp_addrb);
          obs_coefb[enb_cnt] = int'(bus.coef_addrb);
        end
        enb_cnt++;
      end
      if (bus.fir_valid) begin
        lat = n;
        fout = bus.fir_out;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    load_coef(0);
    @(negedge clk);
    #1;
    n_tests++;
    if ({bus.busy, bus.overrun, bus.fir_valid, bus.smp_ena, bus.smp_wea, bus.smp_enb, bus.coef_enb} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000000", {bus.busy, bus.overrun, bus.fir_valid, bus.smp_ena, bus.smp_wea, bus.smp_enb, bus.coef_enb});
    end
    n_tests++;
    if (bus.fir_out !== 16'h0) begin
      n_fail++; $display("FAIL reset_fir_out: got %h expected 0000", bus.fir_out);
    end
    n_tests++;
    if ({bus.smp_addra, bus.smp_addrb, bus.coef_addrb, bus.smp_dia} !== 37'b0) begin
      n_fail++; $display("FAIL reset_addr_data: got %h expected 0", {bus.smp_addra, bus.smp_addrb, bus.coef_addrb, bus.smp_dia});
    end
    rrx_rst = 1'b0;
  endtask

  task automatic test_impulse();
    int ea, lat, wea, enb, aa, idle;
    logic [15:0] fout, dia, e;
    logic pb;
    logic [15:0] golden;
`ifdef RX_LPF_ROUND_EN
    golden = 16'h1234;
`else
    golden = 16'h1233;
`endif
    do_reset();
    clear_mem();
    load_coef(0);
    model_accept(16'h1234, ea);
    run_sample(16'h1234, -1, lat, fout, wea, enb, aa, dia, pb, idle);
    e = exp_q.pop_front();
    n_tests++; if (lat !== 133) begin n_fail++; $display("FAIL impulse_latency: got %0d expected 133", lat); end
    n_tests++; if (fout !== golden) begin n_fail++; $display("FAIL impulse_value: got %h expected %h", fout, golden); end
    n_tests++; if (fout !== e) begin n_fail++; $display("FAIL impulse_model: got %h expected %h", fout, e); end
    n_tests++; if (aa !== 0) begin n_fail++; $display("FAIL impulse_addra: got %0d expected 0", aa); end
    n_tests++; if (dia !== 16'h1234) begin n_fail++; $display("FAIL impulse_dia: got %h expected 1234", dia); end
    n_tests++; if (wea !== 1) begin n_fail++; $display("FAIL impulse_wea_cycles: got %0d expected 1", wea); end
    n_tests++; if (enb !== 128) begin n_fail++; $display("FAIL impulse_enb_cycles: got %0d expected 128", enb); end
    n_tests++; if (obs_addrb[1] !== 127) begin n_fail++; $display("FAIL impulse_addrb_k1: got %0d expected 127", obs_addrb[1]); end
    n_tests++; if (obs_coefb[127] !== 127) begin n_fail++; $display("FAIL impulse_coefb_k127: got %0d expected 127", obs_coefb[127]); end
  endtask

  task automatic test_back_to_back();
    int ea1, ea2, lat1, lat2, wea, enb, aa1, aa2, idle;
    logic [15:0] f1, f2, dia, s1, s2, e1, e2;
    logic pb1, pb2;
    do_reset();
    load_coef(1);
    s1 = 16'($urandom); s2 = 16'($urandom);
    model_accept(s1, ea1);
    model_accept(s2, ea2);
    run_sample(s1, -1, lat1, f1, wea, enb, aa1, dia, pb1, idle);
    run_sample(s2, -1, lat2, f2, wea, enb, aa2, dia, pb2, idle);
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    n_tests++; if (pb2 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_at_t134: got busy=%b expected 0", pb2); end
    n_tests++; if (aa1 !== 0 || aa2 !== 1) begin n_fail++; $display("FAIL b2b_addra: got %0d,%0d expected 0,1", aa1, aa2); end
    n_tests++; if (lat2 !== 133) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 133", lat2); end
    n_tests++; if (f1 !== e1 || f2 !== e2) begin n_fail++; $display("FAIL b2b_values: got %h,%h expected %h,%h", f1, f2, e1, e2); end
    n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_no_overrun: got %b expected 0", bus.overrun); end
  endtask

  task automatic test_overrun();
    int ea, lat, wea, enb, aa, idle;
    logic [15:0] f, dia, s, e;
    logic pb;
    do_reset();
    // first sample with a dropped strobe at t+5
    s = 16'($urandom);
    model_accept(s, ea);
    run_sample(s, 5, lat, f, wea, enb, aa, dia, pb, idle);
    e = exp_q.pop_front();
    n_tests++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b expected 1", bus.overrun); end
    n_tests++; if (f !== e || lat !== 133) begin n_fail++; $display("FAIL overrun_first: got %h lat %0d expected %h lat 133", f, lat, e); end
    n_tests++; if (wea !== 1) begin n_fail++; $display("FAIL overrun_drop_wea: got %0d expected 1", wea); end
    // second sample, with a strobe in the OUT cycle (t+133)
    s = 16'($urandom);
    model_accept(s, ea);
    run_sample(s, 133, lat, f, wea, enb, aa, dia, pb, idle);
    e = exp_q.pop_front();
    n_tests++; if (aa !== 1) begin n_fail++; $display("FAIL overrun_next_addr: got %0d expected 1", aa); end
    n_tests++; if (f !== e) begin n_fail++; $display("FAIL overrun_second: got %h expected %h", f, e); end
    // third sample at t+134: the t+133 strobe must not have been taken
    s = 16'($urandom);
    model_accept(s, ea);
    run_sample(s, -1, lat, f, wea, enb, aa, dia, pb, idle);
    e = exp_q.pop_front();
    n_tests++; if (pb !== 1'b0) begin n_fail++; $display("FAIL overrun_out_cycle_taken: got busy=%b expected 0", pb); end
    n_tests++; if (aa !== 2 || f !== e) begin n_fail++; $display("FAIL overrun_third: got addr %0d val %h expected addr 2 val %h", aa, f, e); end
    n_tests++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b expected 1", bus.overrun); end
  endtask

  task automatic test_reset_mid_mac();
    int ea, lat, wea, enb, aa, idle, fv_cnt;
    logic [15:0] f, dia, s, e;
    logic pb;
    do_reset();
    n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL mid_overrun_cleared: got %b expected 0", bus.overrun); end
    s = 16'($urandom);
    @(negedge clk);
    bus.sample_in = s;
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    model_buf[model_ptr] = s;
    repeat (59) @(negedge clk);
    rrx_rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.busy, bus.smp_ena, bus.smp_wea, bus.smp_enb, bus.coef_enb} !== 5'b0) begin
      n_fail++; $display("FAIL mid_async_drop: got %b expected 00000", {bus.busy, bus.smp_ena, bus.smp_wea, bus.smp_enb, bus.coef_enb});
    end
    fv_cnt = 0;
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      if (n == 2) rrx_rst = 1'b0;
      if (bus.fir_valid) fv_cnt++;
    end
    model_ptr = 0;
    n_tests++; if (fv_cnt !== 0) begin n_fail++; $display("FAIL mid_no_fir_valid: got %0d strobes expected 0", fv_cnt); end
    s = 16'($urandom);
    model_accept(s, ea);
    run_sample(s, -1, lat, f, wea, enb, aa, dia, pb, idle);
    e = exp_q.pop_front();
    n_tests++; if (aa !== 0) begin n_fail++; $display("FAIL mid_next_addr: got %0d expected 0", aa); end
    n_tests++; if (f !== e) begin n_fail++; $display("FAIL mid_next_value: got %h expected %h", f, e); end
  endtask

  task automatic test_wrap();
    int ea, lat, wea, enb, aa, idle, bad;
    logic [15:0] f, dia, s, e;
    logic pb;
    do_reset();
    load_coef(1);
    for (int i = 0; i < 130; i++) begin
      s = 16'($urandom);
      model_accept(s, ea);
      run_sample(s, -1, lat, f, wea, enb, aa, dia, pb, idle);
      e = exp_q.pop_front();
      bad = 0;
      for (int k = 0; k < 128; k++)
        if (obs_addrb[k] != ((ea - k) & 127) || obs_coefb[k] != k) bad++;
      n_tests++; if (aa !== ea) begin n_fail++; $display("FAIL wrap_addra[%0d]: got %0d expected %0d", i, aa, ea); end
      n_tests++; if (f !== e) begin n_fail++; $display("FAIL wrap_value[%0d]: got %h expected %h", i, f, e); end
      n_tests++; if (lat !== 133) begin n_fail++; $display("FAIL wrap_latency[%0d]: got %0d expected 133", i, lat); end
      n_tests++; if (wea !== 1 || enb !== 128) begin n_fail++; $display("FAIL wrap_enables[%0d]: got wea %0d enb %0d expected 1 128", i, wea, enb); end
      n_tests++; if (bad !== 0 || idle !== 0) begin n_fail++; $display("FAIL wrap_addr_walk[%0d]: got %0d bad taps %0d idle enables expected 0 0", i, bad, idle); end
      if (i == 128) begin
        n_tests++;
        if (obs_addrb[1] !== 127 || obs_addrb[127] !== 1) begin
          n_fail++; $display("FAIL wrap_addrb_at_0: got k1=%0d k127=%0d expected 127 1", obs_addrb[1], obs_addrb[127]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int ea, lat, wea, enb, aa, idle;
    logic [15:0] f, dia, e, pat;
    logic pb;
    load_coef(2);
    for (int p = 0; p < 2; p++) begin
      pat = (p == 0) ? 16'h7FFF : 16'h8000;
      for (int i = 0; i < 128; i++) begin
        model_accept(pat, ea);
        run_sample(pat, -1, lat, f, wea, enb, aa, dia, pb, idle);
        e = exp_q.pop_front();
        n_tests++; if (f !== e || lat !== 133) begin n_fail++; $display("FAIL sat_value[%0d][%0d]: got %h lat %0d expected %h lat 133", p, i, f, lat, e); end
      end
      n_tests++; if (f !== pat) begin n_fail++; $display("FAIL sat_final[%0d]: got %h expected %h", p, f, pat); end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sample_in = 16'h0;
    bus.sample_valid = 1'b0;
    test_reset();
    test_impulse();
    test_back_to_back();
    test_overrun();
    test_reset_mid_mac();
    test_wrap();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_low_pass_fir_ctrl.md
Name: rx_low_pass_fir_ctrl

Overview:
- Sequencer and MAC datapath for the receive low-pass FIR.
- Sits directly upstream of, and drives, two 16x128 simple dual-port BRAMs with registered read, 1-cycle latency:
  - a sample circular buffer, written and read;
  - a coefficient store, read only.
- For each accepted input sample it writes the sample, walks all 128 taps, accumulates, and emits one saturated 16-bit filtered sample.

Parameters:
- N_TAPS, 128, number of taps; equals BRAM depth; power of two.
- ADDR_W, 7, BRAM address width, log2(N_TAPS).
- DATA_W, 16, sample, coefficient and output width; signed two's complement.
- ACC_W, 40, accumulator width; must be at least 2*DATA_W + ADDR_W.
- OUT_SHIFT, 15, arithmetic right shift applied to the accumulator before saturation (Q15 coefficients).

Ports:
- clk, in, 1, clock.
- rrx_rst, in, 1, asynchronous active-high reset.
- sample_in, in, 16, input sample.
- sample_valid, in, 1, input sample strobe.
- busy, out, 1, high while a sample is being processed.
- overrun, out, 1, sticky: a sample arrived while busy.
- smp_ena, out, 1, sample BRAM port A enable.
- smp_wea, out, 1, sample BRAM write enable.
- smp_addra, out, 7, sample BRAM write address.
- smp_dia, out, 16, sample BRAM write data.
- smp_enb, out, 1, sample BRAM read enable.
- smp_addrb, out, 7, sample BRAM read address.
- smp_dob, in, 16, sample BRAM read data.
- coef_enb, out, 1, coefficient BRAM read enable.
- coef_addrb, out, 7, coefficient BRAM read address.
- coef_dob, in, 16, coefficient BRAM read data.
- fir_out, out, 16, filtered sample.
- fir_valid, out, 1, one-cycle strobe for fir_out.

Behaviour:
- Reset:
  - All outputs are 0; the FSM goes to IDLE; wr_ptr, tap counter, product register and accumulator are 0.
  - BRAM contents are untouched.
- Reset mid-operation: processing aborts immediately and no fir_valid is produced.
- FSM states: IDLE, WRITE, MAC, DRAIN, OUT.
- Timeline for sample_valid high in IDLE at cycle t:
  - Edge at end of t: latch sample_in and base = wr_ptr; go to WRITE.
  - Cycle t+1 (WRITE): smp_ena = smp_wea = 1, smp_addra = base, smp_dia = latched sample. Edge: wr_ptr <= wr_ptr+1 (mod 128), k <= 0, go to MAC.
  - Cycles t+2..t+129 (MAC, k = 0..127): smp_enb = coef_enb = 1, smp_addrb = (base - k) mod 128, coef_addrb = k.
  - Data for tap k appears at t+3+k.
  - Product register (16x16 signed to 32) captures at the end of t+3+k.
  - Accumulator (sign-extended to ACC_W) adds at the end of t+4+k.
  - The accumulator is cleared in WRITE.
  - After k = 127 go to DRAIN for 3 cycles (t+130..t+132).
  - Edge at end of t+132: fir_out <= sat16(acc >>> OUT_SHIFT); go to OUT.
  - Cycle t+133 (OUT): fir_valid = 1; go to IDLE.
- Latency: fir_valid arrives 133 cycles after the sample_valid cycle.
- busy = (state != IDLE), so busy is high t+1..t+133.
- sample_valid in cycle t+133 is not accepted: in OUT the FSM is not IDLE. The earliest new sample is accepted at t+134.
- Overrun:
  - sample_valid while busy drops the sample and sets overrun.
  - overrun is cleared only by reset.
  - wr_ptr is unaffected by the dropped sample.
- Saturation: results above 32767 give 0x7FFF; results below -32768 give 0x8000.
- Wrap: wr_ptr 127 -> 0. Read addresses wrap modulo 128; newest sample is tap 0.
- Enables are low in all states except those listed.

Optional Feature:
- Macro: RX_LPF_ROUND_EN.
- Defined: add 2^(OUT_SHIFT-1) to the accumulator before the shift (round half up), then saturate.
- Undefined: plain arithmetic shift (floor), then saturate.

Decomposition:
- Package rx_lpf_pkg holds:
  - FSM state encoding;
  - N_TAPS, ADDR_W, DATA_W, ACC_W, OUT_SHIFT;
  - SAT_MAX/SAT_MIN constants.
- Sub-module rx_lpf_mac holds:
  - product register;
  - accumulator with clear/enable;
  - shift, rounding and saturation.
- The top level holds the FSM, pointers and BRAM address generation.

Test Plan:
- Impulse: BRAMs zeroed, coef[0] = 0x7FFF, one sample 0x1234.
  - fir_out = 0x1233 (0x1234 with RX_LPF_ROUND_EN), fir_valid exactly 133 cycles after sample_valid.
  - smp_addra = 0 during the write.
- Saturation:
  - All coef = 0x7FFF, 128 samples of 0x7FFF: last fir_out = 0x7FFF.
  - Repeat with samples 0x8000: fir_out = 0x8000.
- Overrun:
  - sample_valid at t and t+5: second sample dropped, overrun = 1 and stays 1.
  - Next accepted sample writes address 1.
  - sample_valid at t+133 is not accepted; sample_valid at t+134 is accepted with no overrun.
- Wrap: 130 samples.
  - smp_addra sequence ends 127, 0, 1.
  - For the write at address 0, smp_addrb at k = 1 is 127 and at k = 127 is 1.
- Reset mid-MAC: assert rrx_rst at t+60.
  - busy and all enables drop asynchronously; no fir_valid.
  - Next sample writes address 0.
- Enable hygiene:
  - In IDLE, all BRAM enables are 0.
  - smp_wea is high exactly one cycle per accepted sample.
  - smp_enb is high exactly 128 cycles per accepted sample.
